output_packer: RTL and testbench

Sequential write-back block for the accelerator datapath. It accepts a stream of narrow result elements from the PE array and packs them into SRAM_DATA_WIDTH words according to the precision mode. It writes each completed word to consecutive addresses of the output SRAM through the same write port shape the SRAM already exposes (write enable, address, data). It is the writer counterpart of the router: the router reads packed words out of SRAM, and this block packs words back in.

---
 rtl/output_packer_pkg.sv | 45 ++++
 rtl/output_packer_if.sv | 34 +++
 rtl/output_packer_lane_inserter.sv | 30 +++
 rtl/output_packer.sv | 168 ++++++++++++++++
 tb/tb_output_packer.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_packer_pkg.sv
// Shared types and helpers for the output packer and its reader-side sibling, the router.
// Precision modes, FSM states and lane arithmetic live here so both ends agree.
package output_packer_pkg;

    typedef enum logic [1:0] {
        P_8B = 2'b00,
        P_4B = 2'b01,
        P_2B = 2'b10
    } p_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StPack,
        StFlush
    } state_e;

    localparam int unsigned DefaultWordWidth = 64;

    // The reserved encoding 2'b11 behaves as full 8-bit precision.
    function automatic p_mode_e decode_mode(logic [1:0] raw);
        p_mode_e mode;
        case (raw)
            2'b01:   mode = P_4B;
            2'b10:   mode = P_2B;
            default: mode = P_8B;
        endcase
        return mode;
    endfunction

    function automatic int unsigned elem_bits(p_mode_e mode);
        int unsigned bits;
        case (mode)
            P_4B:    bits = 4;
            P_2B:    bits = 2;
            default: bits = 8;
        endcase
        return bits;
    endfunction

    function automatic int unsigned lanes_per_word(p_mode_e mode,
                                                   int unsigned word_width = DefaultWordWidth);
        return word_width / elem_bits(mode);
    endfunction

endpackage

// File: rtl/output_packer_if.sv
// Element stream in from the PE array plus the SRAM write port out of the packer.
// The packer is the slave of the element stream and drives the SRAM side.
interface output_packer_if #(
    parameter int unsigned SRAM_DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned ELEM_WIDTH      = 8
) ();

    logic                       valid;
    logic [ELEM_WIDTH-1:0]      data;
    logic                       ready;
    logic                       write_en;
    logic [ADDR_WIDTH-1:0]      write_addr;
    logic [SRAM_DATA_WIDTH-1:0] data_out;

    modport master (
        output valid,
        output data,
        input  ready,
        input  write_en,
        input  write_addr,
        input  data_out
    );

    modport slave (
        input  valid,
        input  data,
        output ready,
        output write_en,
        output write_addr,
        output data_out
    );

endinterface

// File: rtl/output_packer_lane_inserter.sv
// Combinational lane insert: drops the low W bits of an element into lane `lane_i`
// of the word, W chosen by the precision mode. Other lanes pass through untouched.
module output_packer_lane_inserter
    import output_packer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned ELEM_WIDTH = 8,
    parameter int unsigned LANE_WIDTH = 5
) (
    input  p_mode_e               mode_i,
    input  logic [LANE_WIDTH-1:0] lane_i,
    input  logic [ELEM_WIDTH-1:0] elem_i,
    input  logic [WORD_WIDTH-1:0] word_i,
    output logic [WORD_WIDTH-1:0] word_o
);

    int unsigned           bits;
    int unsigned           shift;
    logic [WORD_WIDTH-1:0] mask;
    logic [WORD_WIDTH-1:0] elem_ext;

    always_comb begin
        bits     = elem_bits(mode_i);
        shift    = 32'(lane_i) * bits;
        mask     = (WORD_WIDTH'(1) << bits) - WORD_WIDTH'(1);
        elem_ext = WORD_WIDTH'(elem_i) & mask;
        word_o   = (word_i & ~(mask << shift)) | (elem_ext << shift);
    end

endmodule

// File: rtl/output_packer.sv
// Packs a stream of narrow PE results into SRAM words and writes them to consecutive
// addresses. Words go out one cycle after the accept that completes them.
module output_packer
    import output_packer_pkg::*;
#(
    parameter int unsigned SRAM_DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned ELEM_WIDTH      = 8,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_reg_clear,
    input  logic [1:0]             i_p_mode,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_start_addr,
    input  logic [COUNT_WIDTH-1:0] i_count,
    output logic                   o_busy,
    output logic                   o_done,
    output_packer_if.slave         bus
);

    // Narrowest mode (2-bit) has the most lanes per word.
    localparam int unsigned LaneWidth = $clog2(SRAM_DATA_WIDTH / 2);

    typedef logic [LaneWidth-1:0]       lane_t;
    typedef logic [ADDR_WIDTH-1:0]      addr_t;
    typedef logic [COUNT_WIDTH-1:0]     count_t;
    typedef logic [SRAM_DATA_WIDTH-1:0] word_t;

    state_e  state_q, state_d;
    p_mode_e mode_q, mode_d;
    addr_t   addr_q, addr_d;
    count_t  count_q, count_d;
    count_t  accepted_q, accepted_d;
    lane_t   lane_q, lane_d;
    word_t   pack_q, pack_d;
    word_t   data_out_q, data_out_d;
    addr_t   write_addr_q, write_addr_d;
    logic    write_en_q, write_en_d;
    logic    done_q, done_d;

    logic  ready;
    logic  accept;
    logic  word_full;
    logic  last_elem;
    word_t inserted;

    output_packer_lane_inserter #(
        .WORD_WIDTH (SRAM_DATA_WIDTH),
        .ELEM_WIDTH (ELEM_WIDTH),
        .LANE_WIDTH (LaneWidth)
    ) u_lane_inserter (
        .mode_i (mode_q),
        .lane_i (lane_q),
        .elem_i (bus.data),
        .word_i (pack_q),
        .word_o (inserted)
    );

    assign ready     = (state_q == StPack);
    assign accept    = bus.valid && ready;
    assign word_full = (32'(lane_q) + 32'd1) == lanes_per_word(mode_q, SRAM_DATA_WIDTH);
    assign last_elem = (accepted_q + count_t'(1)) == count_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        count_d      = count_q;
        accepted_d   = accepted_q;
        lane_d       = lane_q;
        pack_d       = pack_q;
        data_out_d   = data_out_q;
        write_addr_d = write_addr_q;
        write_en_d   = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    mode_d     = decode_mode(i_p_mode);
                    addr_d     = i_start_addr;
                    count_d    = i_count;
                    accepted_d = '0;
                    lane_d     = '0;
                    pack_d     = '0;
                    // An empty job completes immediately without touching the SRAM.
                    if (i_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StPack;
                    end
                end
            end

            StPack: begin
                if (accept) begin
                    accepted_d = accepted_q + count_t'(1);
                    if (last_elem) begin
                        data_out_d   = inserted;
                        write_addr_d = addr_q;
                        write_en_d   = 1'b1;
                        done_d       = 1'b1;
                        lane_d       = '0;
                        pack_d       = '0;
                        state_d      = StFlush;
                    end else if (word_full) begin
                        data_out_d   = inserted;
                        write_addr_d = addr_q;
                        write_en_d   = 1'b1;
                        addr_d       = addr_q + addr_t'(1);
                        lane_d       = '0;
                        pack_d       = '0;
                    end else begin
                        pack_d = inserted;
                        lane_d = lane_q + lane_t'(1);
                    end
                end
            end

            // The final write and done are already registered; this cycle just presents them.
            StFlush: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_reg_clear) begin
            state_q      <= StIdle;
            mode_q       <= P_8B;
            addr_q       <= '0;
            count_q      <= '0;
            accepted_q   <= '0;
            lane_q       <= '0;
            pack_q       <= '0;
            data_out_q   <= '0;
            write_addr_q <= '0;
            write_en_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            accepted_q   <= accepted_d;
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            data_out_q   <= data_out_d;
            write_addr_q <= write_addr_d;
            write_en_q   <= write_en_d;
            done_q       <= done_d;
        end
    end

    assign bus.ready      = ready;
    assign bus.write_en   = write_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.data_out   = data_out_q;
    assign o_busy         = (state_q != StIdle);
    assign o_done         = done_q;

endmodule

// File: tb/tb_output_packer.sv
// Randomized self-checking bench for output_packer; expected SRAM writes come from a
// word/lane arithmetic model of the packing rules.
module tb_output_packer;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 8;
    localparam int unsigned EW = 8;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          reg_clear;
    logic [1:0]    p_mode;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;

    output_packer_if #(.SRAM_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ELEM_WIDTH(EW)) bus ();

    output_packer #(
        .SRAM_DATA_WIDTH (DW),
        .ADDR_WIDTH      (AW),
        .ELEM_WIDTH      (EW),
        .COUNT_WIDTH     (CW)
    ) dut (
        .i_clk        (clk),
        .i_nrst       (rst_n),
        .i_reg_clear  (reg_clear),
        .i_p_mode     (p_mode),
        .i_start      (start),
        .i_start_addr (start_addr),
        .i_count      (count),
        .o_busy       (busy),
        .o_done       (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  elems_q[$];
    int          exp_addr[$];
    logic [63:0] exp_data[$];
    int          obs_addr[$];
    logic [63:0] obs_data[$];
    bit          obs_done[$];
    int          obs_cyc[$];
    int          acc_cyc[$];
    int          done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.write_en === 1'b1) begin
            obs_addr.push_back(int'(bus.write_addr));
            obs_data.push_back(bus.data_out);
            obs_done.push_back(done === 1'b1);
            obs_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_done.delete();
        obs_cyc.delete();
        acc_cyc.delete();
        done_cnt = 0;
    endtask

    // Element i lands in word i/lanes at bit offset (i%lanes)*W; words go to successive addresses.
    task automatic model_job(input logic [1:0] mode, input int saddr);
        int w;
        int lanes;
        w = (mode == 2'b01) ? 4 : (mode == 2'b10) ? 2 : 8;
        lanes = 64 / w;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < elems_q.size(); i++) begin
            if (i % lanes == 0) begin
                exp_addr.push_back((saddr + i / lanes) % 256);
                exp_data.push_back(64'd0);
            end
            exp_data[i / lanes] = exp_data[i / lanes] |
                ((64'(elems_q[i]) & ((64'd1 << w) - 64'd1)) << ((i % lanes) * w));
        end
    endtask

    task automatic drive_job(input logic [1:0] mode, input int saddr, input int gap_min,
                             input int gap_max, input bit scramble);
        int guard;
        clear_obs();
        model_job(mode, saddr);
        p_mode = mode;
        start_addr = AW'(saddr);
        count = CW'(elems_q.size());
        start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) p_mode = 2'($urandom);
        for (int i = 0; i < elems_q.size(); i++) begin
            repeat ($urandom_range(gap_max, gap_min)) begin
                bus.valid = 1'b0;
                bus.data = 8'($urandom);
                tick();
            end
            bus.valid = 1'b1;
            bus.data = elems_q[i];
            guard = 0;
            while (bus.ready !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            tick();
            acc_cyc.push_back(cyc);
        end
        bus.valid = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL job_done_timeout: got no o_done, required a pulse within 20 cycles");
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.valid = 1'b1;
        bus.data = 8'hA5;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        bus.valid = 1'b0;
        n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", bus.ready); end
        n_cmp++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b required 0", bus.write_en); end
        n_cmp++; if (bus.write_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h required 00", bus.write_addr); end
        n_cmp++; if (bus.data_out !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", bus.data_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_8b_full();
        elems_q.delete();
        for (int i = 1; i <= 16; i++) elems_q.push_back(8'(i));
        drive_job(2'b00, 4, 0, 0, 1'b0);
        n_cmp++;
        if (obs_addr.size() != 2) begin
            n_fail++;
            $display("FAIL full8_writes: got %0d writes required 2", obs_addr.size());
        end else begin
            n_cmp++; if (obs_addr[0] != 4 || obs_data[0] !== 64'h0807060504030201) begin n_fail++; $display("FAIL full8_word0: got @%0d %h required @4 0807060504030201", obs_addr[0], obs_data[0]); end
            n_cmp++; if (obs_addr[1] != 5 || obs_data[1] !== 64'h100F0E0D0C0B0A09) begin n_fail++; $display("FAIL full8_word1: got @%0d %h required @5 100F0E0D0C0B0A09", obs_addr[1], obs_data[1]); end
            n_cmp++; if (obs_done[0] || !obs_done[1]) begin n_fail++; $display("FAIL full8_done_align: got done %b/%b required 0/1", obs_done[0], obs_done[1]); end
            n_cmp++; if (obs_cyc[0] != acc_cyc[7] || obs_cyc[1] != acc_cyc[15]) begin n_fail++; $display("FAIL full8_latency: got cycles %0d/%0d required %0d/%0d", obs_cyc[0], obs_cyc[1], acc_cyc[7], acc_cyc[15]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL full8_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_2b_partial();
        elems_q = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
        drive_job(2'b10, 40, 0, 0, 1'b0);
        n_cmp++;
        if (obs_addr.size() != 1) begin
            n_fail++;
            $display("FAIL partial2_writes: got %0d writes required 1", obs_addr.size());
        end else begin
            n_cmp++; if (obs_addr[0] != 40 || obs_data[0] !== 64'h0000000000000139) begin n_fail++; $display("FAIL partial2_word: got @%0d %h required @40 0000000000000139", obs_addr[0], obs_data[0]); end
            n_cmp++; if (!obs_done[0]) begin n_fail++; $display("FAIL partial2_done: got 0 required 1 with the write"); end
        end
    endtask

    task automatic test_4b_gaps();
        elems_q = '{8'hFA, 8'h0B, 8'hFC};
        drive_job(2'b01, 7, 2, 2, 1'b0);
        n_cmp++;
        if (obs_addr.size() != 1) begin
            n_fail++;
            $display("FAIL mask4_writes: got %0d writes required 1", obs_addr.size());
        end else begin
            n_cmp++; if (obs_addr[0] != 7 || obs_data[0] !== 64'h0000000000000CBA) begin n_fail++; $display("FAIL mask4_word: got @%0d %h required @7 0000000000000CBA", obs_addr[0], obs_data[0]); end
        end
    endtask

    task automatic test_addr_wrap();
        elems_q.delete();
        for (int i = 0; i < 9; i++) elems_q.push_back(8'($urandom));
        drive_job(2'b00, 255, 0, 1, 1'b0);
        n_cmp++;
        if (obs_addr.size() != 2) begin
            n_fail++;
            $display("FAIL wrap_writes: got %0d writes required 2", obs_addr.size());
        end else begin
            n_cmp++; if (obs_addr[0] != 255 || obs_addr[1] != 0) begin n_fail++; $display("FAIL wrap_addr: got %0d,%0d required 255,0", obs_addr[0], obs_addr[1]); end
            n_cmp++; if (obs_data[0] !== exp_data[0]) begin n_fail++; $display("FAIL wrap_word0: got %h required %h", obs_data[0], exp_data[0]); end
            n_cmp++; if (obs_data[1] !== 64'(elems_q[8])) begin n_fail++; $display("FAIL wrap_pad: got %h required %h", obs_data[1], 64'(elems_q[8])); end
        end
    endtask

    task automatic test_count0_busy_start();
        clear_obs();
        p_mode = 2'b00;
        start_addr = 8'd77;
        count = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b required 1", done); end
        n_cmp++; if (bus.write_en !== 1'b0) begin n_fail++; $display("FAIL zero_we: got %b required 0", bus.write_en); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b required 0", busy); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b required 0", done); end

        elems_q.delete();
        for (int i = 0; i < 4; i++) elems_q.push_back(8'($urandom));
        clear_obs();
        model_job(2'b00, 10);
        start_addr = 8'd10;
        count = CW'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.valid = 1'b1;
            bus.data = elems_q[i];
            if (i == 2) begin
                start = 1'b1;
                start_addr = 8'd99;
                count = CW'(1);
                p_mode = 2'b10;
            end
            tick();
            start = 1'b0;
        end
        bus.valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (obs_addr.size() != 1) begin
            n_fail++;
            $display("FAIL busy_start_writes: got %0d writes required 1", obs_addr.size());
        end else begin
            n_cmp++; if (obs_addr[0] != 10 || obs_data[0] !== exp_data[0]) begin n_fail++; $display("FAIL busy_start_word: got @%0d %h required @10 %h", obs_addr[0], obs_data[0], exp_data[0]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_reset_midjob();
        clear_obs();
        p_mode = 2'b00;
        start_addr = 8'd20;
        count = CW'(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.valid = 1'b1;
            bus.data = 8'($urandom);
            tick();
        end
        bus.valid = 1'b0;
        rst_n = 1'b0;
        tick();
        n_cmp++; if (bus.ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got ready %b busy %b done %b required 0 0 0", bus.ready, busy, done); end
        n_cmp++; if (bus.write_en !== 1'b0 || bus.write_addr !== 8'h00 || bus.data_out !== 64'h0) begin n_fail++; $display("FAIL midrst_port: got we %b addr %h data %h required all 0", bus.write_en, bus.write_addr, bus.data_out); end
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (obs_addr.size() != 0) begin n_fail++; $display("FAIL midrst_nowrite: got %0d writes required 0", obs_addr.size()); end

        elems_q = '{8'h11, 8'h22, 8'h33};
        drive_job(2'b00, 30, 0, 0, 1'b0);
        n_cmp++; if (obs_addr.size() != 1 || obs_addr[0] != 30 || obs_data[0] !== 64'h0000000000332211) begin n_fail++; $display("FAIL midrst_restart: got %0d writes first @%0d %h required 1 @30 0000000000332211", obs_addr.size(), obs_addr.size() ? obs_addr[0] : -1, obs_data.size() ? obs_data[0] : 64'h0); end

        clear_obs();
        start_addr = 8'd50;
        count = CW'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.valid = 1'b1;
        bus.data = 8'h5A;
        tick();
        bus.valid = 1'b0;
        reg_clear = 1'b1;
        tick();
        reg_clear = 1'b0;
        n_cmp++; if (busy !== 1'b0 || bus.ready !== 1'b0 || bus.data_out !== 64'h0) begin n_fail++; $display("FAIL clear_mid: got busy %b ready %b data %h required 0 0 0", busy, bus.ready, bus.data_out); end
        tick();
    endtask

    task automatic test_random();
        logic [1:0] mode;
        int saddr;
        int n;
        for (int job = 0; job < 20; job++) begin
            mode = 2'($urandom);
            saddr = int'($urandom_range(255, 0));
            n = int'($urandom_range(40, 1));
            elems_q.delete();
            for (int i = 0; i < n; i++) elems_q.push_back(8'($urandom));
            drive_job(mode, saddr, 0, 2, 1'b1);
            n_cmp++;
            if (obs_addr.size() != exp_addr.size()) begin
                n_fail++;
                $display("FAIL rand%0d_writes: got %0d writes required %0d", job, obs_addr.size(), exp_addr.size());
            end else begin
                for (int k = 0; k < exp_addr.size(); k++) begin
                    n_cmp++;
                    if (obs_addr[k] != exp_addr[k] || obs_data[k] !== exp_data[k]) begin
                        n_fail++;
                        $display("FAIL rand%0d_word%0d: got @%0d %h required @%0d %h", job, k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
                    end
                end
                n_cmp++; if (!obs_done[obs_done.size() - 1]) begin n_fail++; $display("FAIL rand%0d_done_align: got 0 required 1 on final write", job); end
            end
            n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done_count: got %0d required 1", job, done_cnt); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        reg_clear = 1'b0;
        p_mode = 2'b00;
        start = 1'b0;
        start_addr = '0;
        count = '0;
        bus.valid = 1'b0;
        bus.data = '0;
        test_reset();
        test_8b_full();
        test_2b_partial();
        test_4b_gaps();
        test_addr_wrap();
        test_count0_busy_start();
        test_reset_midjob();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
